// File: rtl/alu_ab_pkg.sv
// Shared constants for the A/B accumulator datapath of the 4-bit SAP-style CPU.
// Logic opcodes are only decoded when ALU_LOGIC_OPS_EN is defined.
package alu_ab_pkg;

  localparam int DEF_WIDTH = 4;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_XCHG = 4'b0011;
  localparam logic [3:0] OP_STA  = 4'b0110;
  localparam logic [3:0] OP_LDA  = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;

endpackage

// File: rtl/alu_core.sv
// Pure combinational ALU: opcode/A/B -> result, zero, carry, plus a "supported"
// qualifier so the top knows whether eu should capture anything.
// ALU_LOGIC_OPS_EN adds AND/OR/XOR (carry forced to 0).
module alu_core
  import alu_ab_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [3:0]       opcode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             carry_o,
  output logic             valid_o
);

  logic [WIDTH:0] sum;

  // Opcode decode; unsupported opcodes leave valid_o low so state holds.
  always_comb begin
    sum      = '0;
    result_o = '0;
    carry_o  = 1'b0;
    valid_o  = 1'b0;
    case (opcode_i)
      OP_ADD: begin
        sum      = {1'b0, a_i} + {1'b0, b_i};
        result_o = sum[WIDTH-1:0];
        carry_o  = sum[WIDTH];
        valid_o  = 1'b1;
      end
      OP_SUB: begin
        result_o = a_i - b_i;
        carry_o  = (a_i < b_i);
        valid_o  = 1'b1;
      end
`ifdef ALU_LOGIC_OPS_EN
      OP_AND: begin
        result_o = a_i & b_i;
        valid_o  = 1'b1;
      end
      OP_OR: begin
        result_o = a_i | b_i;
        valid_o  = 1'b1;
      end
      OP_XOR: begin
        result_o = a_i ^ b_i;
        valid_o  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_ab_datapath.sv
// A/B accumulator datapath: A and B registers, registered ALU result and
// Z/carry flags, rotate-through-carry, and AND-gated output copies.
// Optional feature macro: ALU_LOGIC_OPS_EN (AND/OR/XOR opcodes in alu_core).
module alu_ab_datapath
  import alu_ab_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] ram_to_a,
  input  logic [WIDTH-1:0] ram_to_b,
  input  logic [WIDTH-1:0] tmp_to_b,
  input  logic [WIDTH-1:0] tmp_to_alu,
  input  logic             carry_in,
  input  logic             la_ram,
  input  logic             la_b,
  input  logic             la_alu,
  input  logic             lb_tmp,
  input  logic             lb_alu,
  input  logic             lpop,
  input  logic             lcarry,
  input  logic             ea_carry,
  input  logic             ercl,
  input  logic             eu,
  input  logic             ea_tmp,
  input  logic             ea_ram,
  input  logic             ea_out,
  input  logic             epush,
  output logic [WIDTH-1:0] a_to_tmp,
  output logic [WIDTH-1:0] a_to_ram,
  output logic [WIDTH-1:0] a_to_out,
  output logic [WIDTH-1:0] b_to_ram,
  output logic             carry_from_a,
  output logic             carry_from_b,
  output logic             z_flag,
  output logic             carry_out
);

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             z_q, z_d, c_q, c_d, cfa_q, cfa_d, cfb_q, cfb_d;
  logic [WIDTH-1:0] alu_res;
  logic             alu_zero, alu_carry, alu_valid;

  // Reserved operand bus, intentionally not consumed by the base op set.
  logic unused_tmp_to_alu;
  assign unused_tmp_to_alu = ^tmp_to_alu;

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .opcode_i (opcode),
    .a_i      (a_q),
    .b_i      (b_q),
    .result_o (alu_res),
    .zero_o   (alu_zero),
    .carry_o  (alu_carry),
    .valid_o  (alu_valid)
  );

  // A next state: la_ram > la_b > la_alu > rotate > hold. la_b sees pre-edge B,
  // which is what makes la_b+lb_tmp an exchange.
  always_comb begin
    a_d   = a_q;
    cfa_d = cfa_q;
    if (la_ram)        a_d = ram_to_a;
    else if (la_b)     a_d = b_q;
    else if (la_alu)   a_d = res_q;
    else if (ea_carry) begin
      a_d   = {a_q[WIDTH-2:0], carry_in};
      cfa_d = a_q[WIDTH-1];
    end
  end

  // B next state: lpop > lb_tmp > lb_alu > lcarry > rotate > hold.
  always_comb begin
    b_d   = b_q;
    cfb_d = cfb_q;
    if (lpop)        b_d = ram_to_b;
    else if (lb_tmp) b_d = tmp_to_b;
    else if (lb_alu) b_d = res_q;
    else if (lcarry) b_d = {{(WIDTH-1){1'b0}}, carry_in};
    else if (ercl) begin
      b_d   = {b_q[WIDTH-2:0], carry_in};
      cfb_d = b_q[WIDTH-1];
    end
  end

  // Capture ALU result and flags on eu for supported opcodes only.
  always_comb begin
    res_d = res_q;
    z_d   = z_q;
    c_d   = c_q;
    if (eu && alu_valid) begin
      res_d = alu_res;
      z_d   = alu_zero;
      c_d   = alu_carry;
    end
  end

  // State registers; reset overrides every strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      cfa_q <= 1'b0;
      cfb_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      res_q <= res_d;
      z_q   <= z_d;
      c_q   <= c_d;
      cfa_q <= cfa_d;
      cfb_q <= cfb_d;
    end
  end

  assign a_to_tmp     = ea_tmp ? a_q : '0;
  assign a_to_ram     = ea_ram ? a_q : '0;
  assign a_to_out     = ea_out ? a_q : '0;
  assign b_to_ram     = epush  ? b_q : '0;
  assign carry_from_a = cfa_q;
  assign carry_from_b = cfb_q;
  assign z_flag       = z_q;
  assign carry_out    = c_q;

endmodule

// File: tb/tb_alu_ab_datapath.sv
// Self-checking bench for alu_ab_datapath: directed scenarios plus a
// randomized run against an integer-arithmetic reference model.
module tb_alu_ab_datapath;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode, ram_to_a, ram_to_b, tmp_to_b, tmp_to_alu;
  logic       carry_in;
  logic       la_ram, la_b, la_alu, lb_tmp, lb_alu, lpop, lcarry;
  logic       ea_carry, ercl, eu, ea_tmp, ea_ram, ea_out, epush;
  logic [3:0] a_to_tmp, a_to_ram, a_to_out, b_to_ram;
  logic       carry_from_a, carry_from_b, z_flag, carry_out;

  int checks   = 0;
  int failures = 0;

  // Reference state
  logic [3:0] ma, mb, mr;
  logic       mz, mc, mcfa, mcfb;

  always #5 clk = ~clk;

  alu_ab_datapath #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .ram_to_a(ram_to_a), .ram_to_b(ram_to_b), .tmp_to_b(tmp_to_b),
    .tmp_to_alu(tmp_to_alu), .carry_in(carry_in),
    .la_ram(la_ram), .la_b(la_b), .la_alu(la_alu),
    .lb_tmp(lb_tmp), .lb_alu(lb_alu), .lpop(lpop), .lcarry(lcarry),
    .ea_carry(ea_carry), .ercl(ercl), .eu(eu),
    .ea_tmp(ea_tmp), .ea_ram(ea_ram), .ea_out(ea_out), .epush(epush),
    .a_to_tmp(a_to_tmp), .a_to_ram(a_to_ram), .a_to_out(a_to_out),
    .b_to_ram(b_to_ram), .carry_from_a(carry_from_a),
    .carry_from_b(carry_from_b), .z_flag(z_flag), .carry_out(carry_out)
  );

  task automatic idle();
    reset = 0; la_ram = 0; la_b = 0; la_alu = 0; lb_tmp = 0; lb_alu = 0;
    lpop = 0; lcarry = 0; ea_carry = 0; ercl = 0; eu = 0;
    ea_tmp = 0; ea_ram = 0; ea_out = 0; epush = 0;
  endtask

  // One clock: model computes next state from the inputs currently driven,
  // then the bench moves to the falling edge for sampling.
  task automatic tick();
    logic [3:0] na, nb, nr;
    logic       nz, nc, ncfa, ncfb;
    int s;
    na = ma; nb = mb; nr = mr; nz = mz; nc = mc; ncfa = mcfa; ncfb = mcfb;
    if (reset) begin
      na = 0; nb = 0; nr = 0; nz = 0; nc = 0; ncfa = 0; ncfb = 0;
    end else begin
      if (la_ram)        na = ram_to_a;
      else if (la_b)     na = mb;
      else if (la_alu)   na = mr;
      else if (ea_carry) begin
        na   = 4'((int'(ma) * 2 + int'(carry_in)) % 16);
        ncfa = (ma >= 4'd8);
      end
      if (lpop)        nb = ram_to_b;
      else if (lb_tmp) nb = tmp_to_b;
      else if (lb_alu) nb = mr;
      else if (lcarry) nb = carry_in ? 4'd1 : 4'd0;
      else if (ercl) begin
        nb   = 4'((int'(mb) * 2 + int'(carry_in)) % 16);
        ncfb = (mb >= 4'd8);
      end
      if (eu) begin
        case (opcode)
          4'd1: begin
            s = int'(ma) + int'(mb);
            nr = 4'(s % 16); nc = (s > 15); nz = (nr == 0);
          end
          4'd2: begin
            s = int'(ma) - int'(mb);
            nr = 4'((s + 16) % 16); nc = (s < 0); nz = (nr == 0);
          end
`ifdef ALU_LOGIC_OPS_EN
          4'd8:  begin nr = ma & mb; nc = 0; nz = (nr == 0); end
          4'd9:  begin nr = ma | mb; nc = 0; nz = (nr == 0); end
          4'd10: begin nr = ma ^ mb; nc = 0; nz = (nr == 0); end
`endif
          default: ;
        endcase
      end
    end
    @(posedge clk);
    ma = na; mb = nb; mr = nr; mz = nz; mc = nc; mcfa = ncfa; mcfb = ncfb;
    @(negedge clk);
  endtask

  task automatic set_ab(input logic [3:0] a, input logic [3:0] b);
    idle(); ram_to_a = a; ram_to_b = b; la_ram = 1; lpop = 1; tick(); idle();
  endtask

  task automatic test_reset();
    idle(); reset = 1; la_ram = 1; ram_to_a = 4'd9; eu = 1; opcode = 4'd1;
    ea_tmp = 1; ea_ram = 1; ea_out = 1; epush = 1;
    tick(); tick();
    checks++;
    if ({a_to_tmp, a_to_ram, a_to_out, b_to_ram} !== 16'h0) begin
      failures++; $display("FAIL reset_gated got=%h want=0000", {a_to_tmp, a_to_ram, a_to_out, b_to_ram});
    end
    checks++;
    if ({z_flag, carry_out, carry_from_a, carry_from_b} !== 4'b0) begin
      failures++; $display("FAIL reset_flags got=%b want=0000", {z_flag, carry_out, carry_from_a, carry_from_b});
    end
    idle();
  endtask

  task automatic test_load_gate();
    idle(); ram_to_a = 4'd1; la_ram = 1; tick(); idle();
    ea_ram = 1; #1;
    checks++;
    if (a_to_ram !== 4'd1) begin failures++; $display("FAIL gate_on got=%h want=1", a_to_ram); end
    ea_ram = 0; #1;
    checks++;
    if (a_to_ram !== 4'd0) begin failures++; $display("FAIL gate_off got=%h want=0", a_to_ram); end
  endtask

  task automatic test_xchg();
    set_ab(4'd1, 4'd0);
    tmp_to_b = 4'd1; la_b = 1; lb_tmp = 1; tick(); idle();
    ea_out = 1; epush = 1; #1;
    checks++;
    if (a_to_out !== 4'd0 || b_to_ram !== 4'd1) begin
      failures++; $display("FAIL xchg got A=%h B=%h want A=0 B=1", a_to_out, b_to_ram);
    end
    idle();
  endtask

  task automatic test_sub();
    set_ab(4'd8, 4'd1);
    opcode = 4'b0010; eu = 1; tick(); idle(); la_alu = 1; tick(); idle();
    ea_out = 1; #1;
    checks++;
    if (a_to_out !== 4'd7 || z_flag !== 1'b0 || carry_out !== 1'b0) begin
      failures++; $display("FAIL sub_8_1 got A=%h z=%b c=%b want A=7 z=0 c=0", a_to_out, z_flag, carry_out);
    end
    set_ab(4'd0, 4'd1);
    eu = 1; tick(); idle(); la_alu = 1; ea_out = 1; tick();
    checks++;
    if (a_to_out !== 4'hF || carry_out !== 1'b1 || z_flag !== 1'b0) begin
      failures++; $display("FAIL sub_borrow got A=%h z=%b c=%b want A=f z=0 c=1", a_to_out, z_flag, carry_out);
    end
    set_ab(4'd1, 4'd1);
    eu = 1; tick(); idle();
    checks++;
    if (z_flag !== 1'b1 || carry_out !== 1'b0) begin
      failures++; $display("FAIL sub_zero got z=%b c=%b want z=1 c=0", z_flag, carry_out);
    end
  endtask

  task automatic test_add_and_hold();
    set_ab(4'hF, 4'd1);
    opcode = 4'b0001; eu = 1; tick(); idle();
    checks++;
    if (z_flag !== 1'b1 || carry_out !== 1'b1) begin
      failures++; $display("FAIL add_wrap got z=%b c=%b want z=1 c=1", z_flag, carry_out);
    end
    // Unsupported opcode: eu must not disturb result or flags.
    set_ab(4'd3, 4'd4);
    opcode = 4'b0011; eu = 1; tick(); idle();
    checks++;
    if (z_flag !== 1'b1 || carry_out !== 1'b1) begin
      failures++; $display("FAIL xchg_op_hold got z=%b c=%b want z=1 c=1", z_flag, carry_out);
    end
    // eu with la_alu: A takes the previously captured result (0), not 7.
    opcode = 4'b0001; eu = 1; la_alu = 1; tick(); idle();
    ea_out = 1; #1;
    checks++;
    if (a_to_out !== 4'd0 || z_flag !== 1'b0 || carry_out !== 1'b0) begin
      failures++; $display("FAIL eu_la_alu got A=%h z=%b c=%b want A=0 z=0 c=0", a_to_out, z_flag, carry_out);
    end
    idle(); la_alu = 1; ea_out = 1; tick();
    checks++;
    if (a_to_out !== 4'd7) begin failures++; $display("FAIL la_alu_next got=%h want=7", a_to_out); end
    idle();
  endtask

  task automatic test_rotate();
    set_ab(4'b1100, 4'b1001);
    carry_in = 0; ercl = 1; tick(); idle(); epush = 1; #1;
    checks++;
    if (b_to_ram !== 4'b0010 || carry_from_b !== 1'b1) begin
      failures++; $display("FAIL rcl_b got B=%b cfb=%b want B=0010 cfb=1", b_to_ram, carry_from_b);
    end
    idle(); carry_in = 1; ea_carry = 1; tick(); idle(); ea_tmp = 1; #1;
    checks++;
    if (a_to_tmp !== 4'b1001 || carry_from_a !== 1'b1) begin
      failures++; $display("FAIL rcl_a got A=%b cfa=%b want A=1001 cfa=1", a_to_tmp, carry_from_a);
    end
    idle(); carry_in = 1; lcarry = 1; tick(); idle(); epush = 1; #1;
    checks++;
    if (b_to_ram !== 4'd1) begin failures++; $display("FAIL lcarry got=%h want=1", b_to_ram); end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 40) == 0);
      opcode   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'($urandom_range(1, 2));
      ram_to_a = 4'($urandom); ram_to_b = 4'($urandom);
      tmp_to_b = 4'($urandom); tmp_to_alu = 4'($urandom);
      carry_in = 1'($urandom);
      la_ram = ($urandom_range(0, 5) == 0); la_b   = ($urandom_range(0, 5) == 0);
      la_alu = ($urandom_range(0, 5) == 0); lb_tmp = ($urandom_range(0, 5) == 0);
      lb_alu = ($urandom_range(0, 5) == 0); lpop   = ($urandom_range(0, 5) == 0);
      lcarry = ($urandom_range(0, 5) == 0); ea_carry = ($urandom_range(0, 3) == 0);
      ercl   = ($urandom_range(0, 3) == 0); eu     = ($urandom_range(0, 2) == 0);
      ea_tmp = 1'($urandom); ea_ram = 1'($urandom);
      ea_out = 1'($urandom); epush  = 1'($urandom);
      tick();
      checks++;
      if (a_to_tmp !== (ea_tmp ? ma : 4'd0) || a_to_ram !== (ea_ram ? ma : 4'd0) ||
          a_to_out !== (ea_out ? ma : 4'd0) || b_to_ram !== (epush ? mb : 4'd0)) begin
        failures++;
        $display("FAIL rand_regs cyc=%0d got tmp=%h ram=%h out=%h push=%h want A=%h B=%h",
                 i, a_to_tmp, a_to_ram, a_to_out, b_to_ram, ma, mb);
      end
      checks++;
      if ({z_flag, carry_out, carry_from_a, carry_from_b} !== {mz, mc, mcfa, mcfb}) begin
        failures++;
        $display("FAIL rand_flags cyc=%0d got=%b want=%b", i,
                 {z_flag, carry_out, carry_from_a, carry_from_b}, {mz, mc, mcfa, mcfb});
      end
      // Captured result observed through A on the following cycle.
      idle(); la_alu = 1; ea_out = 1; tick();
      checks++;
      if (a_to_out !== mr) begin
        failures++; $display("FAIL rand_result cyc=%0d got=%h want=%h", i, a_to_out, mr);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    set_ab(4'd5, 4'd6);
    opcode = 4'd1; eu = 1; tick();
    reset = 1; la_ram = 1; ram_to_a = 4'hA; lpop = 1; ram_to_b = 4'hB;
    eu = 1; ea_carry = 1; ercl = 1; tick(); idle();
    ea_out = 1; epush = 1; #1;
    checks++;
    if ({a_to_out, b_to_ram, z_flag, carry_out} !== 10'h0) begin
      failures++; $display("FAIL reset_mid got A=%h B=%h z=%b c=%b want all 0", a_to_out, b_to_ram, z_flag, carry_out);
    end
    idle();
  endtask

  initial begin
    opcode = 0; ram_to_a = 0; ram_to_b = 0; tmp_to_b = 0; tmp_to_alu = 0; carry_in = 0;
    ma = 0; mb = 0; mr = 0; mz = 0; mc = 0; mcfa = 0; mcfb = 0;
    idle();
    @(negedge clk);
    test_reset();
    test_load_gate();
    test_xchg();
    test_sub();
    test_add_and_hold();
    test_rotate();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
